peridot_spi_fifo_master: RTL and testbench

//  Parametrised SPI master: byte transfers, TX/RX FIFOs and SS_NUM slave selects, on an Avalon-MM slave.

---
 rtl/peridot_spi_fifo_master_pkg.sv | 39 +++
 rtl/peridot_spi_fifo_master_bytefifo.sv | 58 +++++
 rtl/peridot_spi_fifo_master.sv | 228 ++++++++++++++++++++++
 tb/tb_peridot_spi_fifo_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/peridot_spi_fifo_master_pkg.sv
// Shared definitions for the PERIDOT SPI FIFO master: register map, bit positions,
// engine state encodings and the bit-reversal helper.
package peridot_spi_fifo_master_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CONFIG = 2'd2;
  localparam logic [1:0] REG_SELECT = 2'd3;

  localparam int STAT_TXIRQENA = 15;
  localparam int STAT_RXIRQENA = 14;
  localparam int STAT_BUSY     = 13;
  localparam int STAT_TXFULL   = 12;
  localparam int STAT_TXEMPTY  = 11;
  localparam int STAT_RXFULL   = 10;
  localparam int STAT_RXEMPTY  = 9;
  localparam int STAT_RXCLR    = 1;
  localparam int STAT_TXCLR    = 0;

  localparam int CONF_BITRVS     = 15;
  localparam int CONF_MODE_LSB   = 12;
  localparam int CONF_CLKDIV_LSB = 0;

  // DONE keeps the gen1 encoding of all ones
  typedef enum logic [4:0] {
    STATE_IDLE  = 5'd0,
    STATE_ENTRY = 5'd1,
    STATE_SDI   = 5'd2,
    STATE_SDO   = 5'd3,
    STATE_DONE  = 5'd31
  } spi_state_t;

  function automatic logic [7:0] bit_reverse(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

endpackage

// File: rtl/peridot_spi_fifo_master_bytefifo.sv
// Synchronous byte FIFO with show-ahead read data; clear has priority over push and pop.
module peridot_spi_fifo_master_bytefifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_sig,
  input  logic                  reset_sig,
  input  logic                  clr,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock_sig) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/peridot_spi_fifo_master.sv
// PERIDOT SPI master: Avalon-MM register file, TX/RX byte FIFOs and a byte-serial
// shift engine that streams queued bytes back-to-back.
module peridot_spi_fifo_master #(
  parameter int         SS_NUM             = 1,
  parameter int         FIFO_DEPTH_LOG2    = 4,
  parameter logic       DEFAULT_REG_BITRVS = 1'b0,
  parameter logic [1:0] DEFAULT_REG_MODE   = 2'd0,
  parameter logic [7:0] DEFAULT_REG_CLKDIV = 8'd255
) (
  input  logic              clock_sig,
  input  logic              reset_sig,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic              ins_irq,
  output logic [SS_NUM-1:0] spi_ss_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  import peridot_spi_fifo_master_pkg::*;

  logic              tx_irq_ena, rx_irq_ena, bitrvs;
  logic [1:0]        mode;
  logic [7:0]        clkdiv;
  logic [SS_NUM-1:0] ss;

  spi_state_t state, state_next;
  logic [7:0] divcount, tx_shift, rx_shift;
  logic [2:0] bitcount;
  logic       sclk;
  logic       div_zero, last_bit, busy;
  logic       load, sample, shift, toggle, count_bit, rx_push;

  logic                     wr_data, wr_status, wr_config, wr_select, rd_data;
  logic                     tx_clr, rx_clr;
  logic [7:0]               tx_wdata, tx_rdata, rx_rdata, rx_byte;
  logic                     tx_full, tx_empty, rx_full, rx_empty;
  logic [FIFO_DEPTH_LOG2:0] tx_level, rx_level;
  logic                     unused_wdata;

  assign wr_data   = avs_write & (avs_address == REG_DATA);
  assign wr_status = avs_write & (avs_address == REG_STATUS);
  assign wr_config = avs_write & (avs_address == REG_CONFIG);
  assign wr_select = avs_write & (avs_address == REG_SELECT);
  assign rd_data   = avs_read  & (avs_address == REG_DATA);

  assign tx_clr   = wr_status & avs_writedata[STAT_TXCLR];
  assign rx_clr   = wr_status & avs_writedata[STAT_RXCLR];
  // Bytes are stored MSB-first on TX, so LSB-first mode reverses on the way in and out
  assign tx_wdata = bitrvs ? bit_reverse(avs_writedata[7:0]) : avs_writedata[7:0];
  assign rx_byte  = bitrvs ? bit_reverse(rx_rdata) : rx_rdata;

  assign unused_wdata = ^{avs_writedata[31:16], avs_writedata[11:8]};

  peridot_spi_fifo_master_bytefifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .clr       (tx_clr),
    .push      (wr_data),
    .wdata     (tx_wdata),
    .pop       (load),
    .rdata     (tx_rdata),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  peridot_spi_fifo_master_bytefifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .clr       (rx_clr),
    .push      (rx_push),
    .wdata     (rx_shift),
    .pop       (rd_data),
    .rdata     (rx_rdata),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      tx_irq_ena <= 1'b0;
      rx_irq_ena <= 1'b0;
      bitrvs     <= DEFAULT_REG_BITRVS;
      mode       <= DEFAULT_REG_MODE;
      clkdiv     <= DEFAULT_REG_CLKDIV;
      ss         <= '0;
    end else begin
      if (wr_status) begin
        tx_irq_ena <= avs_writedata[STAT_TXIRQENA];
        rx_irq_ena <= avs_writedata[STAT_RXIRQENA];
      end
      if (wr_config && !busy) begin
        bitrvs <= avs_writedata[CONF_BITRVS];
        mode   <= avs_writedata[CONF_MODE_LSB +: 2];
        clkdiv <= avs_writedata[CONF_CLKDIV_LSB +: 8];
      end
      if (wr_select) ss <= avs_writedata[SS_NUM-1:0];
    end
  end

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      REG_DATA: begin
        if (!rx_empty) avs_readdata[8:0] = {1'b1, rx_byte};
      end
      REG_STATUS: begin
        avs_readdata[31:24]         = 8'(tx_level);
        avs_readdata[23:16]         = 8'(rx_level);
        avs_readdata[STAT_TXIRQENA] = tx_irq_ena;
        avs_readdata[STAT_RXIRQENA] = rx_irq_ena;
        avs_readdata[STAT_BUSY]     = busy;
        avs_readdata[STAT_TXFULL]   = tx_full;
        avs_readdata[STAT_TXEMPTY]  = tx_empty;
        avs_readdata[STAT_RXFULL]   = rx_full;
        avs_readdata[STAT_RXEMPTY]  = rx_empty;
      end
      REG_CONFIG: begin
        avs_readdata[CONF_BITRVS]            = bitrvs;
        avs_readdata[CONF_MODE_LSB +: 2]     = mode;
        avs_readdata[CONF_CLKDIV_LSB +: 8]   = clkdiv;
      end
      default: begin
        avs_readdata[SS_NUM-1:0] = ss;
      end
    endcase
  end

  assign busy     = (state != STATE_IDLE);
  assign div_zero = (divcount == 8'd0);
  assign last_bit = (bitcount == 3'd7);

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) state <= STATE_IDLE;
    else           state <= state_next;
  end

  // CPHA selects whether a bit is counted on leaving SDI (sample edge) or SDO (shift edge)
  always_comb begin
    state_next = state;
    load       = 1'b0;
    sample     = 1'b0;
    shift      = 1'b0;
    toggle     = 1'b0;
    count_bit  = 1'b0;
    rx_push    = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (!tx_empty && !rx_full) begin
          load       = 1'b1;
          state_next = mode[0] ? STATE_ENTRY : STATE_SDI;
        end
      end
      STATE_ENTRY: begin
        if (div_zero) begin
          toggle     = 1'b1;
          state_next = STATE_SDI;
        end
      end
      STATE_SDI: begin
        if (div_zero) begin
          sample = 1'b1;
          toggle = 1'b1;
          if (mode[0]) begin
            count_bit  = 1'b1;
            state_next = last_bit ? STATE_DONE : STATE_SDO;
          end else begin
            state_next = STATE_SDO;
          end
        end
      end
      STATE_SDO: begin
        if (div_zero) begin
          shift  = 1'b1;
          toggle = 1'b1;
          if (!mode[0]) begin
            count_bit  = 1'b1;
            state_next = last_bit ? STATE_DONE : STATE_SDI;
          end else begin
            state_next = STATE_SDI;
          end
        end
      end
      STATE_DONE: begin
        if (div_zero) begin
          rx_push    = 1'b1;
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      divcount <= 8'd0;
      bitcount <= 3'd0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      sclk     <= DEFAULT_REG_MODE[1];
    end else if (load) begin
      tx_shift <= tx_rdata;
      divcount <= clkdiv;
      bitcount <= 3'd0;
      sclk     <= mode[1];
    end else if (state == STATE_IDLE) begin
      sclk <= mode[1];
    end else begin
      divcount <= div_zero ? clkdiv : divcount - 8'd1;
      if (toggle)    sclk     <= ~sclk;
      if (sample)    rx_shift <= {rx_shift[6:0], spi_miso};
      if (shift)     tx_shift <= {tx_shift[6:0], 1'b0};
      if (count_bit) bitcount <= bitcount + 3'd1;
    end
  end

  assign spi_ss_n = ~ss;
  assign spi_sclk = sclk;
  assign spi_mosi = tx_shift[7];
  assign ins_irq  = (tx_irq_ena & tx_empty & ~busy) | (rx_irq_ena & ~rx_empty);

endmodule

// File: tb/tb_peridot_spi_fifo_master.sv
// Directed bench for peridot_spi_fifo_master with MISO looped back to MOSI.
module tb_peridot_spi_fifo_master;

  logic        clock_sig = 1'b0;
  logic        reset_sig = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        ins_irq;
  logic [1:0]  spi_ss_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  int vectors = 0;
  int miscompares = 0;

  assign spi_miso = spi_mosi;

  peridot_spi_fifo_master #(
    .SS_NUM             (2),
    .FIFO_DEPTH_LOG2    (4),
    .DEFAULT_REG_BITRVS (1'b0),
    .DEFAULT_REG_MODE   (2'd0),
    .DEFAULT_REG_CLKDIV (8'd255)
  ) dut (
    .clock_sig     (clock_sig),
    .reset_sig     (reset_sig),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .ins_irq       (ins_irq),
    .spi_ss_n      (spi_ss_n),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso)
  );

  always #5 clock_sig = ~clock_sig;

  // sclk edge log: cycle index, new level and mosi at the moment of each edge
  int   cyc = 0;
  logic sclk_prev = 1'b0;
  int   edge_cyc[$];
  logic edge_val[$];
  logic edge_mosi[$];

  always @(negedge clock_sig) begin
    cyc++;
    if (spi_sclk !== sclk_prev) begin
      edge_cyc.push_back(cyc);
      edge_val.push_back(spi_sclk);
      edge_mosi.push_back(spi_mosi);
    end
    sclk_prev = spi_sclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clock_sig);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(posedge clock_sig);
    #1 avs_write = 1'b0;
  endtask

  task automatic readRegister(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clock_sig);
    avs_address = addr;
    avs_read    = 1'b1;
    #1 data = avs_readdata;
    @(posedge clock_sig);
    #1 avs_read = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock_sig);
  endtask

  // idle engine with nothing it can start: TX empty or RX full
  task automatic waitQuiet(input string tag);
    logic [31:0] s;
    logic        done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      readRegister(2'd1, s);
      if (!s[13] && (s[11] || s[10])) done = 1'b1;
    end
    checkOutput({tag, "_quiet"}, 32'(done), 32'd1);
  endtask

  task automatic waitIrqHigh(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clock_sig);
      #1 if (ins_irq === 1'b1) found = 1'b1;
    end
    checkOutput({tag, "_irq_rise"}, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  mm;
    int          base;
    int          bad;
    logic        found;

    #1 reset_sig = 1'b1;
    repeat (3) @(negedge clock_sig);
    reset_sig = 1'b0;

    // Reset state
    $display("[TB] reset state");
    checkOutput("rst_sclk", 32'(spi_sclk), 32'd0);
    checkOutput("rst_ss_n", 32'(spi_ss_n), 32'd3);
    checkOutput("rst_irq", 32'(ins_irq), 32'd0);
    checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
    readRegister(2'd1, rd); checkOutput("rst_status", rd, 32'h0000_0A00);
    readRegister(2'd2, rd); checkOutput("rst_config", rd, 32'h0000_00FF);
    readRegister(2'd3, rd); checkOutput("rst_select", rd, 32'h0000_0000);
    readRegister(2'd0, rd); checkOutput("rst_data_empty", rd, 32'h0000_0000);

    // Mode 0, clkdiv 1, one byte looped back
    $display("[TB] mode 0 loopback");
    applyStimulus(2'd2, 32'h0000_0001);
    base = edge_cyc.size();
    applyStimulus(2'd0, 32'h0000_00A5);
    waitQuiet("t1");
    checkOutput("t1_edges", 32'(edge_cyc.size() - base), 32'd16);
    bad = 0;
    for (int i = base + 1; i < base + 16 && i < edge_cyc.size(); i++)
      if (edge_cyc[i] - edge_cyc[i-1] != 2) bad++;
    checkOutput("t1_halfperiod_bad", 32'(bad), 32'd0);
    checkOutput("t1_first_edge", 32'((edge_val.size() > base) ? edge_val[base] : 1'bx), 32'd1);
    readRegister(2'd1, rd); checkOutput("t1_status", rd, 32'h0001_0800);
    readRegister(2'd0, rd); checkOutput("t1_data", rd, 32'h0000_01A5);
    readRegister(2'd0, rd); checkOutput("t1_data_again", rd, 32'h0000_0000);

    // Modes 1..3, LSB-first, byte 0x01
    $display("[TB] modes 1-3 bit-reversed");
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      applyStimulus(2'd2, 32'h0000_8001 | (32'(mm) << 12));
      waitCycles(3);
      checkOutput($sformatf("t2_m%0d_idle_sclk", m), 32'(spi_sclk), 32'(mm[1]));
      base = edge_cyc.size();
      applyStimulus(2'd0, 32'h0000_0001);
      waitQuiet($sformatf("t2_m%0d", m));
      checkOutput($sformatf("t2_m%0d_edges", m), 32'(edge_cyc.size() - base), 32'd16);
      checkOutput($sformatf("t2_m%0d_first_mosi", m),
                  32'((edge_mosi.size() > base) ? edge_mosi[base] : 1'bx), 32'd1);
      checkOutput($sformatf("t2_m%0d_end_sclk", m), 32'(spi_sclk), 32'(mm[1]));
      readRegister(2'd0, rd); checkOutput($sformatf("t2_m%0d_data", m), rd, 32'h0000_0101);
    end

    // Fill RX to 16, then overflow TX while the engine is stalled
    $display("[TB] fifo full and stall");
    applyStimulus(2'd2, 32'h0000_0000);
    for (int i = 0; i < 16; i++) applyStimulus(2'd0, 32'h50 + 32'(i));
    waitQuiet("t4_fill");
    readRegister(2'd1, rd); checkOutput("t4_status_rxfull", rd, 32'h0010_0C00);
    base = edge_cyc.size();
    for (int i = 0; i < 17; i++) applyStimulus(2'd0, 32'h70 + 32'(i));
    waitCycles(20);
    checkOutput("t4_sclk_static", 32'(edge_cyc.size() - base), 32'd0);
    readRegister(2'd1, rd); checkOutput("t3_status_txfull", rd, 32'h1010_1400);
    base = edge_cyc.size();
    readRegister(2'd0, rd); checkOutput("t4_first_pop", rd, 32'h0000_0150);
    waitQuiet("t4_resume");
    checkOutput("t4_one_byte_edges", 32'(edge_cyc.size() - base), 32'd16);
    readRegister(2'd1, rd); checkOutput("t4_status_after", rd, 32'h0F10_0400);
    readRegister(2'd0, rd); checkOutput("t4_second_pop", rd, 32'h0000_0151);
    applyStimulus(2'd1, 32'h0000_0001);
    waitQuiet("t4_txclr");
    readRegister(2'd1, rd); checkOutput("t4_status_txclr", rd, 32'h0010_0C00);
    applyStimulus(2'd1, 32'h0000_0002);
    readRegister(2'd1, rd); checkOutput("t4_status_rxclr", rd, 32'h0000_0A00);
    readRegister(2'd0, rd); checkOutput("t4_data_cleared", rd, 32'h0000_0000);

    // TX-empty interrupt across a three-byte burst
    $display("[TB] irq");
    applyStimulus(2'd2, 32'h0000_0001);
    applyStimulus(2'd1, 32'h0000_8000);
    waitCycles(1);
    checkOutput("t5_irq_idle_empty", 32'(ins_irq), 32'd1);
    base = edge_cyc.size();
    applyStimulus(2'd0, 32'h0000_003C);
    applyStimulus(2'd0, 32'h0000_00C3);
    applyStimulus(2'd0, 32'h0000_005A);
    checkOutput("t5_irq_low_queued", 32'(ins_irq), 32'd0);
    waitIrqHigh("t5_tx");
    checkOutput("t5_edges_at_irq", 32'(edge_cyc.size() - base), 32'd48);
    readRegister(2'd1, rd); checkOutput("t5_status_at_irq", rd, 32'h0003_8800);

    // RX-not-empty interrupt
    applyStimulus(2'd1, 32'h0000_4002);
    waitCycles(1);
    checkOutput("t5_rxirq_empty", 32'(ins_irq), 32'd0);
    applyStimulus(2'd0, 32'h0000_003C);
    applyStimulus(2'd0, 32'h0000_00C3);
    waitIrqHigh("t5_rx");
    waitQuiet("t5_rx");
    readRegister(2'd0, rd); checkOutput("t5_rx_data0", rd, 32'h0000_013C);
    checkOutput("t5_irq_one_left", 32'(ins_irq), 32'd1);
    readRegister(2'd0, rd); checkOutput("t5_rx_data1", rd, 32'h0000_01C3);
    checkOutput("t5_irq_drained", 32'(ins_irq), 32'd0);

    // Reset in the middle of a transfer
    $display("[TB] reset mid-transfer");
    applyStimulus(2'd1, 32'h0000_0000);
    applyStimulus(2'd2, 32'h0000_2007);
    applyStimulus(2'd3, 32'h0000_0001);
    waitCycles(1);
    checkOutput("t6_ss_n", 32'(spi_ss_n), 32'd2);
    readRegister(2'd3, rd); checkOutput("t6_select", rd, 32'h0000_0001);
    applyStimulus(2'd0, 32'h0000_00F0);
    applyStimulus(2'd0, 32'h0000_000F);
    waitCycles(3);
    applyStimulus(2'd2, 32'h0000_0003);
    readRegister(2'd2, rd); checkOutput("t6_config_busy_ignored", rd, 32'h0000_2007);
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clock_sig);
      if (spi_sclk === 1'b0) found = 1'b1;
    end
    checkOutput("t6_reach_sdo", 32'(found), 32'd1);
    waitCycles(2);
    #2 reset_sig = 1'b1;
    #1;
    checkOutput("t6_rst_sclk", 32'(spi_sclk), 32'd0);
    checkOutput("t6_rst_ss_n", 32'(spi_ss_n), 32'd3);
    checkOutput("t6_rst_mosi", 32'(spi_mosi), 32'd0);
    waitCycles(2);
    reset_sig = 1'b0;
    checkOutput("t6_rst_irq", 32'(ins_irq), 32'd0);
    readRegister(2'd1, rd); checkOutput("t6_status", rd, 32'h0000_0A00);
    readRegister(2'd2, rd); checkOutput("t6_config", rd, 32'h0000_00FF);
    readRegister(2'd3, rd); checkOutput("t6_select_rst", rd, 32'h0000_0000);
    waitCycles(200);
    readRegister(2'd0, rd); checkOutput("t6_no_partial_byte", rd, 32'h0000_0000);
    readRegister(2'd1, rd); checkOutput("t6_status_later", rd, 32'h0000_0A00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
